// File: rtl/uart_tx_top.sv
// uart_tx_top: LSB-first UART transmitter fed by a valid/ready word port.
// Define UART_TX_STOP2_EN for two stop bits per frame.
module uart_tx_top #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  UCLK,
   input  logic                  reset,
   input  logic                  parity_enable,
   input  logic                  parity_type,
   input  logic [5:0]            prescale,
   input  logic                  data_valid,
   input  logic [DATA_WIDTH-1:0] parallel_data,
   output logic                  tx_ready,
   output logic                  busy,
   output logic                  tx_done,
   output logic                  serial_data_out
);

   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state_q, state_d;
   logic [5:0]            timer_q, timer_d;
   logic [5:0]            presc_q, presc_d;
   logic [5:0]            presc_sat;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_type_q, par_type_d;
   logic                  line_q, line_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
`ifdef UART_TX_STOP2_EN
   logic                  stop2_q, stop2_d;
`endif
   logic                  accept;
   logic                  last;

   assign presc_sat = (prescale < 6'd4) ? 6'd4 : prescale;
   assign accept    = data_valid && ready_q && (state_q == IDLE);
   assign last      = (timer_q == 6'd0);

   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_type_d = par_type_q;
      line_d     = line_q;
      done_d     = 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_d    = stop2_q;
`endif
      timer_d    = (state_q != IDLE && !last) ? timer_q - 6'd1 : timer_q;

      unique case (state_q)
         IDLE: begin
            line_d = 1'b1;
            if (accept) begin
               state_d    = START;
               data_d     = parallel_data;
               shift_d    = parallel_data;
               par_en_d   = parity_enable;
               par_type_d = parity_type;
               presc_d    = presc_sat;
               timer_d    = presc_sat - 6'd1;
               line_d     = 1'b0;
            end
         end
         START: begin
            if (last) begin
               state_d = DATA;
               timer_d = presc_q - 6'd1;
               idx_d   = '0;
               line_d  = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         DATA: begin
            if (last) begin
               timer_d = presc_q - 6'd1;
               if (idx_q == IW'(DATA_WIDTH - 1)) begin
                  idx_d = '0;
                  if (par_en_q) begin
                     state_d = PARITY;
                     line_d  = ^data_q ^ par_type_q;
                  end else begin
                     state_d = STOP;
                     line_d  = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + 1'b1;
                  line_d  = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (last) begin
               state_d = STOP;
               timer_d = presc_q - 6'd1;
               line_d  = 1'b1;
            end
         end
         STOP: begin
            if (last) begin
`ifdef UART_TX_STOP2_EN
               if (!stop2_q) begin
                  stop2_d = 1'b1;
                  timer_d = presc_q - 6'd1;
               end else begin
                  stop2_d = 1'b0;
                  state_d = IDLE;
                  done_d  = 1'b1;
                  line_d  = 1'b1;
               end
`else
               state_d = IDLE;
               done_d  = 1'b1;
               line_d  = 1'b1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            line_d  = 1'b1;
         end
      endcase

      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge UCLK) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         presc_q    <= 6'd4;
         idx_q      <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         line_q     <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef UART_TX_STOP2_EN
         stop2_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_type_q <= par_type_d;
         line_q     <= line_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef UART_TX_STOP2_EN
         stop2_q    <= stop2_d;
`endif
      end
   end

   assign tx_ready        = ready_q;
   assign busy            = busy_q;
   assign tx_done         = done_q;
   assign serial_data_out = line_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// tb_uart_tx_top: table vectors, corner sequences and random frames
// checked against a bit-list line model and a mid-bit sampling receiver.
module tb_uart_tx_top;

   localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
   localparam int STOPS = 2;
`else
   localparam int STOPS = 1;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          pe, pt, dv;
   logic [5:0]    ps;
   logic [DW-1:0] pd;
   logic          tx_ready, busy, tx_done, serial_data_out;

   uart_tx_top #(.DATA_WIDTH(DW)) dut (
      .UCLK           (clk),
      .reset          (reset),
      .parity_enable  (pe),
      .parity_type    (pt),
      .prescale       (ps),
      .data_valid     (dv),
      .parallel_data  (pd),
      .tx_ready       (tx_ready),
      .busy           (busy),
      .tx_done        (tx_done),
      .serial_data_out(serial_data_out)
   );

   always #5 clk = ~clk;

   int            nvec = 0;
   int            nmis = 0;
   int            done_at;
   int            par_seen;
   logic [DW-1:0] rx_word;

   typedef struct {
      logic [DW-1:0] d;
      bit            e;
      bit            t;
      logic [5:0]    p;
      bit            scr;
      int            len;
      bit            par;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input bit ok,
                      input longint act, input longint exp);
      nvec++;
      if (!ok) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Starts at a negedge with the DUT idle; returns at the negedge after
   // tx_done (chain=1) or one cycle later with the line idle (chain=0).
   task automatic run_frame(input logic [DW-1:0] d, input bit e,
                            input bit t, input logic [5:0] p_in,
                            input bit scr, input bit chain);
      int p;
      int n;
      int idx;
      int bad_line;
      int bad_stat;
      bit bits[$];
      p        = (p_in < 6'd4) ? 4 : int'(p_in);
      bad_line = 0;
      bad_stat = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < DW; i++) bits.push_back(d[i]);
      if (e) bits.push_back(^d ^ t);
      for (int i = 0; i < STOPS; i++) bits.push_back(1'b1);
      n = bits.size();

      chk("ready_pre", tx_ready === 1'b1, tx_ready, 1);
      pd = d; pe = e; pt = t; ps = p_in; dv = 1'b1;
      done_at  = -1;
      par_seen = -1;
      rx_word  = '0;

      for (int c = 0; c <= n * p; c++) begin
         @(negedge clk);
         if (c == 0 && !chain) dv = 1'b0;
         if (c == 0 && scr) begin
            pd = ~d; ps = 6'd63; pe = ~e; pt = ~t;
         end
         if (tx_done === 1'b1 && done_at < 0) done_at = c;
         if (c < n * p) begin
            if (serial_data_out !== bits[c / p]) bad_line++;
            if (busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0)
               bad_stat++;
            if (c % p == p / 2) begin
               idx = c / p;
               if (idx >= 1 && idx <= DW) rx_word[idx-1] = serial_data_out;
               if (e && idx == DW + 1) par_seen = int'(serial_data_out);
            end
         end
      end

      chk("frame_line", bad_line == 0, bad_line, 0);
      chk("frame_status", bad_stat == 0, bad_stat, 0);
      chk("rx_word", rx_word === d, rx_word, d);
      if (e) chk("rx_parity", par_seen == int'(^d ^ t), par_seen, ^d ^ t);
      chk("end_state",
          {tx_done, tx_ready, busy, serial_data_out} === 4'b1101,
          {tx_done, tx_ready, busy, serial_data_out}, 4'b1101);
      if (!chain) begin
         @(negedge clk);
         chk("done_pulse",
             {tx_done, tx_ready, busy, serial_data_out} === 4'b0101,
             {tx_done, tx_ready, busy, serial_data_out}, 4'b0101);
      end
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic [5:0]    rp;

      reset = 1'b1; dv = 1'b0; pe = 1'b0; pt = 1'b0; ps = 6'd8; pd = '0;
      repeat (3) @(negedge clk);
      chk("reset_state",
          {tx_done, tx_ready, busy, serial_data_out} === 4'b0101,
          {tx_done, tx_ready, busy, serial_data_out}, 4'b0101);
      reset = 1'b0;
      @(negedge clk);

      tbl.push_back('{8'hA5, 1'b0, 1'b0, 6'd8,  1'b0, 80,  1'b0});
      tbl.push_back('{8'hA5, 1'b1, 1'b0, 6'd8,  1'b0, 88,  1'b0});
      tbl.push_back('{8'hA5, 1'b1, 1'b1, 6'd8,  1'b0, 88,  1'b1});
      tbl.push_back('{8'h3C, 1'b1, 1'b1, 6'd2,  1'b1, 44,  1'b1});
      tbl.push_back('{8'h01, 1'b1, 1'b0, 6'd4,  1'b0, 44,  1'b1});
      tbl.push_back('{8'h7F, 1'b1, 1'b0, 6'd5,  1'b1, 55,  1'b1});
      tbl.push_back('{8'h80, 1'b0, 1'b1, 6'd63, 1'b0, 630, 1'b0});
      tbl.push_back('{8'h5E, 1'b0, 1'b0, 6'd0,  1'b0, 40,  1'b0});

      foreach (tbl[i]) begin
         int pe_eff;
         pe_eff = (tbl[i].p < 6'd4) ? 4 : int'(tbl[i].p);
         run_frame(tbl[i].d, tbl[i].e, tbl[i].t, tbl[i].p, tbl[i].scr, 1'b0);
         chk("done_cycle", done_at == tbl[i].len + (STOPS - 1) * pe_eff,
             done_at, tbl[i].len + (STOPS - 1) * pe_eff);
         if (tbl[i].e)
            chk("parity_bit", par_seen == int'(tbl[i].par),
                par_seen, tbl[i].par);
      end

      // back-to-back with data_valid held high
      run_frame(8'h00, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
      pd = 8'hFF;
      run_frame(8'hFF, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);

      // reset 30 cycles into a frame
      pd = 8'h5A; ps = 6'd8; pe = 1'b1; pt = 1'b0; dv = 1'b1;
      @(negedge clk);
      dv = 1'b0;
      repeat (29) @(negedge clk);
      chk("busy_before_reset", busy === 1'b1, busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_state",
          {tx_done, tx_ready, busy, serial_data_out} === 4'b0101,
          {tx_done, tx_ready, busy, serial_data_out}, 4'b0101);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_no_done", tx_done === 1'b0, tx_done, 0);
      run_frame(8'hC3, 1'b1, 1'b1, 6'd8, 1'b0, 1'b0);

      for (int k = 0; k < 256; k++) begin
         rd = DW'($urandom);
         case ($urandom_range(0, 2))
            0:       rp = 6'd8;
            1:       rp = 6'd16;
            default: rp = 6'd32;
         endcase
         run_frame(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   rp, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
